// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS datapath decode path.
//   - opcode constants for the supported instruction set
//   - immediate-extender opcode encodings (EXT_*)
//   - decoded_t: field bundle produced by ifid_field_dec
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [1:0]  ext_op;
    logic        illegal;
  } decoded_t;

endpackage

// File: rtl/ifid_field_dec.sv
// ifid_field_dec: combinational instruction-word -> decoded_t decoder.
// Ports:
//   instr_i  in  32 : instruction word
//   dec_o    out    : register fields, imm16, extender opcode, illegal flag
module ifid_field_dec
  import mips_pkg::*;
(
  input  logic [31:0] instr_i,
  output decoded_t    dec_o
);

  // Field split plus extender-opcode / legality lookup on the opcode
  always_comb begin
    dec_o.opcode  = instr_i[31:26];
    dec_o.rs      = instr_i[25:21];
    dec_o.rt      = instr_i[20:16];
    dec_o.rd      = instr_i[15:11];
    dec_o.shamt   = instr_i[10:6];
    dec_o.funct   = instr_i[5:0];
    dec_o.imm16   = instr_i[15:0];
    dec_o.ext_op  = EXT_SIGN;
    dec_o.illegal = 1'b0;
    case (instr_i[31:26])
      OP_ANDI, OP_ORI, OP_XORI: dec_o.ext_op = EXT_ZERO;
      OP_LUI:                   dec_o.ext_op = EXT_LUI;
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LB, OP_LW, OP_LBU, OP_SB, OP_SW: dec_o.ext_op = EXT_SIGN;
      // Unknown opcodes still hand the extender a defined (sign) op
      default:                  dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ifid_decode.sv
// ifid_decode: IF/ID pipeline register with field decode and valid/ready
// handshake, stall and flush handling.
// Build option: define IFID_SKID_EN for a 1-entry skid buffer, which makes
// in_ready independent of out_ready.
// Ports:
//   clk, rst_n (async, active low)
//   in_valid/in_ready/in_instr/in_pc   : fetch side
//   flush                              : kill all held instructions
//   out_valid/out_ready                : decode side handshake
//   out_instr/out_pc                   : registered word and PC
//   out_opcode/rs/rt/rd/shamt/funct    : instruction fields
//   out_imm16/out_ext_op/out_illegal   : extender inputs and legality
module ifid_decode
  import mips_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [5:0]      out_opcode,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_shamt,
  output logic [5:0]      out_funct,
  output logic [15:0]     out_imm16,
  output logic [1:0]      out_ext_op,
  output logic            out_illegal
);

  decoded_t        dec_s;
  logic            accept_s;
  logic            fire_s;
  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc_q, pc_d;
  decoded_t        dec_q, dec_d;

  ifid_field_dec u_field_dec (
    .instr_i (in_instr),
    .dec_o   (dec_s)
  );

  assign accept_s = in_valid & in_ready;
  assign fire_s   = valid_q & out_ready;

`ifdef IFID_SKID_EN
  logic            skid_valid_q, skid_valid_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [PC_W-1:0] skid_pc_q, skid_pc_d;
  decoded_t        skid_dec_q, skid_dec_d;

  // Only the skid occupancy (a flop) and flush gate acceptance
  assign in_ready = rst_n & ~flush & ~skid_valid_q;

  // Next state for output register and skid entry
  always_comb begin
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    dec_d        = dec_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_dec_d   = skid_dec_q;
    if (flush) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (fire_s && skid_valid_q) begin
      // Skid full implies in_ready=0, so no new word competes here
      instr_d      = skid_instr_q;
      pc_d         = skid_pc_q;
      dec_d        = skid_dec_q;
      skid_valid_d = 1'b0;
    end else if (accept_s && (!valid_q || out_ready)) begin
      valid_d = 1'b1;
      instr_d = in_instr;
      pc_d    = in_pc;
      dec_d   = dec_s;
    end else if (accept_s) begin
      // Output stalled: park the word behind it
      skid_valid_d = 1'b1;
      skid_instr_d = in_instr;
      skid_pc_d    = in_pc;
      skid_dec_d   = dec_s;
    end else if (fire_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Skid entry register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_instr_q <= 32'h0000_0000;
      skid_pc_q    <= '0;
      skid_dec_q   <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_dec_q   <= skid_dec_d;
    end
  end
`else
  // Accept when empty or when the held word leaves this same edge
  assign in_ready = rst_n & ~flush & (~valid_q | out_ready);

  // Next state for the single output register
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    dec_d   = dec_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d = 1'b1;
      instr_d = in_instr;
      pc_d    = in_pc;
      dec_d   = dec_s;
    end else if (fire_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end
`endif

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0000_0000;
      pc_q    <= '0;
      dec_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      dec_q   <= dec_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_instr   = instr_q;
  assign out_pc      = pc_q;
  assign out_opcode  = dec_q.opcode;
  assign out_rs      = dec_q.rs;
  assign out_rt      = dec_q.rt;
  assign out_rd      = dec_q.rd;
  assign out_shamt   = dec_q.shamt;
  assign out_funct   = dec_q.funct;
  assign out_imm16   = dec_q.imm16;
  assign out_ext_op  = dec_q.ext_op;
  assign out_illegal = dec_q.illegal;

endmodule

// File: tb/tb_ifid_decode.sv
module tb_ifid_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic [31:0] in_pc = 32'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [5:0]  out_funct;
  logic [15:0] out_imm16;
  logic [1:0]  out_ext_op;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  logic [31:0] pc_ctr = 32'h0000_3000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;
  item_t sb_q[$];

  ifid_decode #(.PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_imm16(out_imm16),
    .out_ext_op(out_ext_op), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: expected decoder bundle from the instruction word
  function automatic logic [114:0] ref_bundle(input logic [31:0] w, input logic [31:0] pc);
    logic [1:0] ext;
    logic       ill;
    int op;
    op  = int'(w[31:26]);
    ill = 1'b0;
    if (op == 12 || op == 13 || op == 14) ext = 2'b00;
    else if (op == 15) ext = 2'b10;
    else begin
      ext = 2'b01;
      if (!(op == 0 || op == 2 || op == 3 || op == 4 || op == 5 ||
            (op >= 8 && op <= 11) || op == 32 || op == 35 || op == 36 ||
            op == 40 || op == 43)) ill = 1'b1;
    end
    return {w, pc, w[31:26], w[25:21], w[20:16], w[15:11], w[10:6], w[5:0],
            w[15:0], ext, ill};
  endfunction

  function automatic logic [114:0] dut_bundle();
    return {out_instr, out_pc, out_opcode, out_rs, out_rt, out_rd, out_shamt,
            out_funct, out_imm16, out_ext_op, out_illegal};
  endfunction

  // One clock of stimulus; checks handshake against the held-word count model
  task automatic cycle(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
    logic exp_rdy;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_instr  = w;
    in_pc     = pc_ctr;
    out_ready = ordy;
    flush     = fl;
    #3;
`ifdef IFID_SKID_EN
    exp_rdy = !fl && (sb_q.size() < 2);
`else
    exp_rdy = !fl && (sb_q.size() == 0 || ordy);
`endif
    chk("in_ready", {127'b0, in_ready}, {127'b0, exp_rdy});
    chk("out_valid", {127'b0, out_valid}, {127'b0, sb_q.size() != 0});
    if (v && in_ready) acc_cnt++;
    if (fl) sb_q.delete();
    else if (v && exp_rdy) begin
      sb_q.push_back('{instr: w, pc: pc_ctr});
      pc_ctr = pc_ctr + 32'd4;
    end
  endtask

  // Monitor: compare the presented word against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && out_valid && !flush) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out", {127'b0, out_valid}, 128'd0);
      end else begin
        chk("out_word", {13'b0, dut_bundle()}, {13'b0, ref_bundle(sb_q[0].instr, sb_q[0].pc)});
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_fields", {13'b0, dut_bundle()}, 128'd0);
    chk("rst_in_ready", {127'b0, in_ready}, 128'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {127'b0, in_ready}, 128'd1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [0:18];
    logic [31:0] w;
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h23, 6'h24, 6'h28, 6'h2B, 6'h3F};
    w = $urandom;
    if ($urandom_range(0, 3) != 0) w[31:26] = ops[$urandom_range(0, 18)];
    return w;
  endfunction

  initial begin
    int accepted;
    repeat (2) @(posedge clk);
    #1;
    chk("init_out_valid", {127'b0, out_valid}, 128'd0);
    rst_n = 1'b1;
    #1;
    chk("init_in_ready", {127'b0, in_ready}, 128'd1);

    // ori
    cycle(1'b1, 32'h3401_1234, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("ori_rt", {123'b0, out_rt}, 128'd1);
    chk("ori_imm", {112'b0, out_imm16}, 128'h1234);
    chk("ori_ext", {126'b0, out_ext_op}, 128'd0);
    chk("ori_pc", {96'b0, out_pc}, 128'h3000);

    // lui then lw back-to-back
    cycle(1'b1, 32'h3C01_ABCD, 1'b1, 1'b0);
    cycle(1'b1, 32'h8C22_FFFC, 1'b1, 1'b0);
    chk("lui_ext", {126'b0, out_ext_op}, 128'd2);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("lw_ext", {126'b0, out_ext_op}, 128'd1);
    chk("lw_rs", {123'b0, out_rs}, 128'd1);
    chk("lw_rt", {123'b0, out_rt}, 128'd2);
    chk("lw_imm", {112'b0, out_imm16}, 128'hFFFC);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // illegal opcode
    cycle(1'b1, 32'hFC00_0000, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("ill_flag", {127'b0, out_illegal}, 128'd1);
    chk("ill_ext", {126'b0, out_ext_op}, 128'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // stall for 3 cycles with input offered
    cycle(1'b1, 32'h2001_0001, 1'b0, 1'b0);
    acc_cnt = 0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h2002_0010 + 32'(i), 1'b0, 1'b0);
    accepted = acc_cnt;
`ifdef IFID_SKID_EN
    chk("stall_accepts", 128'(accepted), 128'd1);
`else
    chk("stall_accepts", 128'(accepted), 128'd0);
`endif
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // flush while holding a word and offering another
    cycle(1'b1, 32'h2003_0003, 1'b0, 1'b0);
    acc_cnt = 0;
    cycle(1'b1, 32'h2004_0004, 1'b0, 1'b1);
    chk("flush_no_accept", 128'(acc_cnt), 128'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("flush_cleared", {127'b0, out_valid}, 128'd0);

    // randomized traffic with a reset in mid-stream
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
    end

    // drain
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drained", 128'(sb_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
